edf_dispatcher: RTL

//  Downstream consumer of the per-core request Queues. Each cycle it watches up to NB_CORES queue heads.
//  It picks the non-empty queue whose absolute deadline is earliest (EDF) and issues that head to the memory port.

---
 rtl/memoredf_pkg.sv | 18 +
 rtl/edf_min_select.sv | 31 +++
 rtl/edf_dispatcher.sv | 114 +++++++++++
 3 files changed

// File: rtl/memoredf_pkg.sv
// Shared types for the EDF memory dispatcher: FSM states, deadline type and
// the wrap-aware "earlier" compare used by the min-select.
package memoredf_pkg;

  localparam int DL_W = 16;

  typedef enum logic [1:0] {IDLE, ARB, ISSUE, SETTLE} dispatch_state_t;
  typedef logic [DL_W-1:0] deadline_t;

  // a precedes b when the modular distance a-b is negative; valid while
  // live deadlines stay within half the time-base range of each other
  function automatic logic earlier(deadline_t a, deadline_t b);
    deadline_t d;
    d = a - b;
    return d[DL_W-1];
  endfunction

endpackage

// File: rtl/edf_min_select.sv
// Combinational NB_CORES-way earliest-deadline select over a candidate mask.
// A later index only replaces the current best if strictly earlier, so ties go low.
module edf_min_select
  import memoredf_pkg::*;
#(
  parameter int NB_CORES = 4
) (
  input  logic                        [NB_CORES-1:0] mask,
  input  deadline_t                   [NB_CORES-1:0] deadline,
  output logic [$clog2(NB_CORES)-1:0]                winner,
  output logic                                       valid
);

  localparam int IDX_W = $clog2(NB_CORES);

  deadline_t best;

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    best   = '0;
    for (int i = 0; i < NB_CORES; i++) begin
      if (mask[i] && (!valid || earlier(deadline[i], best))) begin
        valid  = 1'b1;
        winner = IDX_W'(i);
        best   = deadline[i];
      end
    end
  end

endmodule

// File: rtl/edf_dispatcher.sv
// EDF dispatcher: picks the non-empty queue head with the earliest absolute
// deadline, issues it over valid/ready and pulses that queue's consumed line.
module edf_dispatcher
  import memoredf_pkg::*;
#(
  parameter int NB_CORES       = 4,
  parameter int DATA_SIZE      = 8,
  parameter int REGISTER_SIZE  = 32,
  parameter int DEADLINE_WIDTH = DL_W
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [NB_CORES*REGISTER_SIZE-1:0] period,
  input  logic [NB_CORES-1:0]           queue_empty,
  input  logic [NB_CORES*DATA_SIZE-1:0] queue_head,
  output logic [NB_CORES-1:0]           queue_consumed,
  output logic [DATA_SIZE-1:0]          req_data,
  output logic [$clog2(NB_CORES)-1:0]   req_core,
  output logic                          req_valid,
  input  logic                          req_ready,
  output logic [NB_CORES-1:0]           deadline_miss
);

  localparam int IDX_W = $clog2(NB_CORES);

  dispatch_state_t state;

  logic [DEADLINE_WIDTH-1:0]                now;
  logic [NB_CORES-1:0][DEADLINE_WIDTH-1:0]  deadline;
  logic [NB_CORES-1:0][DEADLINE_WIDTH-1:0]  per;
  logic [NB_CORES-1:0][DEADLINE_WIDTH-1:0]  sel_dl;
  logic [NB_CORES-1:0]                      prev_empty;
  logic [NB_CORES-1:0]                      is_rt;
  logic [NB_CORES-1:0]                      rt_cand;
  logic [NB_CORES-1:0]                      be_cand;
  logic [NB_CORES-1:0]                      sel_mask;
  logic [IDX_W-1:0]                         win;
  logic                                     win_ok;
  logic                                     any_head;

  for (genvar i = 0; i < NB_CORES; i++) begin : g_core
    assign per[i]   = period[i*REGISTER_SIZE +: DEADLINE_WIDTH];
    assign is_rt[i] = |period[i*REGISTER_SIZE +: REGISTER_SIZE];
  end

  // A head that only just appeared has no loaded deadline yet; it joins
  // arbitration one cycle later, which is exactly when ARB samples it.
  assign rt_cand  = ~queue_empty & ~prev_empty & is_rt;
  assign be_cand  = ~queue_empty & ~prev_empty & ~is_rt;
  assign any_head = |(~queue_empty);
  assign sel_mask = (|rt_cand) ? rt_cand  : be_cand;
  assign sel_dl   = (|rt_cand) ? deadline : '0;

  edf_min_select #(.NB_CORES(NB_CORES)) u_min_select (
    .mask     (sel_mask),
    .deadline (sel_dl),
    .winner   (win),
    .valid    (win_ok)
  );

  assign queue_consumed = (state == ISSUE && req_ready) ? (NB_CORES'(1) << req_core) : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      req_valid  <= 1'b0;
      req_data   <= '0;
      req_core   <= '0;
      now        <= '0;
      prev_empty <= '1;
    end else begin
      now        <= now + DEADLINE_WIDTH'(1);
      prev_empty <= queue_empty;
      case (state)
        IDLE:   if (enable && any_head) state <= ARB;
        ARB: begin
          if (win_ok) begin
            req_core  <= win;
            req_data  <= queue_head[int'(win)*DATA_SIZE +: DATA_SIZE];
            req_valid <= 1'b1;
            state     <= ISSUE;
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          if (req_ready) begin
            req_valid <= 1'b0;
            state     <= SETTLE;
          end
        end
        SETTLE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Deadline reload on arrival, or after service while entries remain.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      deadline      <= '0;
      deadline_miss <= '0;
    end else begin
      for (int i = 0; i < NB_CORES; i++) begin
        if ((prev_empty[i] || (state == SETTLE && int'(req_core) == i)) && !queue_empty[i])
          deadline[i] <= now + per[i];
        if (rt_cand[i] && now == deadline[i] && !queue_consumed[i])
          deadline_miss[i] <= 1'b1;
      end
    end
  end

endmodule
